// File: rtl/dds_pkg.sv
// Shared constants for the DDS sine/cosine generator: widths, quadrant encoding
// and the elaboration-time quarter-sine table generator.
package dds_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH  = 6;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam string DEF_INIT_FILE = "QuarterSine.hex";

    // Quadrant field sits above the table index: bit 0 mirrors, bit 1 negates.
    localparam int QUAD_WIDTH      = 2;
    localparam int QUAD_MIRROR_BIT = 0;
    localparam int QUAD_NEG_BIT    = 1;
    localparam logic [QUAD_WIDTH-1:0] QUAD_COS_STEP = 2'b01;

    localparam longint PI_Q30 = 64'sd3373259426;

    // round((2^(data_w-1)-1) * sin(pi/2 * (k+0.5) / 2^addr_w)) in Q30 integer arithmetic.
    function automatic longint quarter_sine_entry(input int k, input int addr_w, input int data_w);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        x    = (PI_Q30 * longint'(2 * k + 1)) / (longint'(4) <<< addr_w);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        amp = (longint'(1) <<< (data_w - 1)) - 1;
        return (sum * amp + (longint'(1) <<< 29)) >>> 30;
    endfunction

endpackage

// File: rtl/dds_sine_gen_if.sv
// Control and sample bus of the DDS generator; the controller is master, the generator slave.
interface dds_sine_gen_if
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) ();

    logic                          en;
    logic                          clr;
    logic        [PHASE_WIDTH-1:0] phase_inc;
    logic        [PHASE_WIDTH-1:0] phase_off;
    logic signed [DATA_WIDTH-1:0]  sin_out;
    logic signed [DATA_WIDTH-1:0]  cos_out;
    logic                          valid;

    modport master (
        output en, clr, phase_inc, phase_off,
        input  sin_out, cos_out, valid
    );

    modport slave (
        input  en, clr, phase_inc, phase_off,
        output sin_out, cos_out, valid
    );

endinterface

// File: rtl/quarter_sine_rom.sv
// Quarter-period sine magnitude table with two synchronous read ports sharing one enable.
module quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAG_WIDTH  = DEF_DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [MAG_WIDTH-1:0]  data_a,
    output logic [MAG_WIDTH-1:0]  data_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [MAG_WIDTH-1:0] rom [DEPTH];

    // Contents are fixed at elaboration, so the array folds into ROM initial values.
    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam logic [MAG_WIDTH-1:0] ENTRY =
            MAG_WIDTH'(quarter_sine_entry(k, ADDR_WIDTH, MAG_WIDTH + 1));
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine/cosine generator: phase accumulator, quarter-wave fold, shared ROM, sign restore.
// The sample for the accumulator value before enabled edge k is on the outputs after edge k+2.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input logic           clk,
    input logic           rst,
    dds_sine_gen_if.slave bus
);

    localparam int MAG_WIDTH = DATA_WIDTH - 1;
    localparam int T_WIDTH   = ADDR_WIDTH + QUAD_WIDTH;
    localparam logic [T_WIDTH-1:0] COS_ADVANCE = {QUAD_COS_STEP, {ADDR_WIDTH{1'b0}}};

    logic [PHASE_WIDTH-1:0] acc_p0;
    logic [T_WIDTH-1:0]     t_sin;
    logic [T_WIDTH-1:0]     t_cos;
    logic [ADDR_WIDTH:0]    sin_fold;
    logic [ADDR_WIDTH:0]    cos_fold;
    logic [ADDR_WIDTH-1:0]  sin_addr_p1;
    logic [ADDR_WIDTH-1:0]  cos_addr_p1;
    logic                   sin_neg_p1;
    logic                   cos_neg_p1;
    logic [MAG_WIDTH-1:0]   sin_mag_p2;
    logic [MAG_WIDTH-1:0]   cos_mag_p2;
    logic                   sin_neg_p2;
    logic                   cos_neg_p2;
    logic                   vld_p1;
    logic                   vld_p2;
    logic                   vld_p3;
    logic                   advance;

    // Returns {negate, table address} for a quadrant+index phase word.
    function automatic logic [ADDR_WIDTH:0] fold(input logic [T_WIDTH-1:0] t);
        logic [ADDR_WIDTH-1:0] idx;
        idx = t[ADDR_WIDTH-1:0];
        return {t[ADDR_WIDTH + QUAD_NEG_BIT], t[ADDR_WIDTH + QUAD_MIRROR_BIT] ? ~idx : idx};
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] apply_sign(input logic neg,
                                                                 input logic [MAG_WIDTH-1:0] mag);
        logic signed [DATA_WIDTH-1:0] ext;
        ext = signed'({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // clr freezes the data path for one edge while the accumulator restarts.
    assign advance  = bus.en & ~bus.clr;
    assign t_sin    = T_WIDTH'((acc_p0 + bus.phase_off) >> (PHASE_WIDTH - T_WIDTH));
    assign t_cos    = t_sin + COS_ADVANCE;
    assign sin_fold = fold(t_sin);
    assign cos_fold = fold(t_cos);

    // Stage 0: accumulator and valid shift register
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            acc_p0 <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (bus.en) begin
            acc_p0 <= acc_p0 + bus.phase_inc;
            vld_p1 <= 1'b1;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Stage 1: folded addresses and signs
    always_ff @(posedge clk) begin
        if (rst) begin
            sin_addr_p1 <= '0;
            cos_addr_p1 <= '0;
            sin_neg_p1  <= 1'b0;
            cos_neg_p1  <= 1'b0;
        end else if (advance) begin
            sin_addr_p1 <= sin_fold[ADDR_WIDTH-1:0];
            cos_addr_p1 <= cos_fold[ADDR_WIDTH-1:0];
            sin_neg_p1  <= sin_fold[ADDR_WIDTH];
            cos_neg_p1  <= cos_fold[ADDR_WIDTH];
        end
    end

    // Stage 2: ROM magnitudes, signs delayed alongside
    quarter_sine_rom #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAG_WIDTH  (MAG_WIDTH)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .addr_a (sin_addr_p1),
        .addr_b (cos_addr_p1),
        .data_a (sin_mag_p2),
        .data_b (cos_mag_p2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_neg_p2 <= 1'b0;
            cos_neg_p2 <= 1'b0;
        end else if (advance) begin
            sin_neg_p2 <= sin_neg_p1;
            cos_neg_p2 <= cos_neg_p1;
        end
    end

    // Stage 3: signed outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sin_out <= '0;
            bus.cos_out <= '0;
        end else if (advance) begin
            bus.sin_out <= apply_sign(sin_neg_p2, sin_mag_p2);
            bus.cos_out <= apply_sign(cos_neg_p2, cos_mag_p2);
        end
    end

    assign bus.valid = vld_p3;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Bench for dds_sine_gen: directed scenarios plus randomized control, scored against a
// real-valued sine/cosine model with a queue of expected samples.
module tb_dds_sine_gen;
    import dds_pkg::*;

    localparam int PW = 32;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int STEPS = 4 << AW;
    localparam logic [PW-1:0] INC = 32'h0100_0000;
    localparam logic [PW-1:0] HALF = 32'h8000_0000;
    localparam real PI_R = 3.14159265358979323846;
    localparam real AMP = real'((1 << (DW - 1)) - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_pass = 0;
    logic [PW-1:0] m_acc = '0;
    int live = 0;
    int hist_s[$];
    int hist_c[$];
    int s_arr[0:259];
    int c_arr[0:259];
    int snap_s;
    int snap_c;
    logic [PW-1:0] inc_r;
    logic [PW-1:0] off_r;

    always #5 clk = ~clk;

    dds_sine_gen_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    dds_sine_gen #(
        .PHASE_WIDTH (PW),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    // Ideal sample of the quantised phase (top AW+2 bits), centred in its bin.
    function automatic int ref_wave(input logic [PW-1:0] p, input bit want_cos);
        real ang;
        real v;
        ang = 2.0 * PI_R * (real'(p >> (PW - AW - 2)) + 0.5) / real'(STEPS);
        v = AMP * (want_cos ? $cos(ang) : $sin(ang));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic step(input logic r, input logic e, input logic c,
                        input logic [PW-1:0] inc, input logic [PW-1:0] off);
        rst = r;
        bus.en = e;
        bus.clr = c;
        bus.phase_inc = inc;
        bus.phase_off = off;
        @(posedge clk);
        if (r) begin
            m_acc = '0;
            live = 0;
            hist_s.delete();
            hist_c.delete();
        end else if (c) begin
            m_acc = '0;
            live = 0;
        end else if (e) begin
            hist_s.push_back(ref_wave(m_acc + off, 1'b0));
            hist_c.push_back(ref_wave(m_acc + off, 1'b1));
            live++;
            m_acc = m_acc + inc;
        end
        @(negedge clk);
        if (r) begin
            check("rst_sin", bus.sin_out, 0);
            check("rst_cos", bus.cos_out, 0);
            check("rst_valid", bus.valid, 0);
        end else begin
            check("valid", bus.valid, (live >= 3) ? 1 : 0);
            if (live >= 3) begin
                check("sin", bus.sin_out, hist_s[hist_s.size() - 3]);
                check("cos", bus.cos_out, hist_c[hist_c.size() - 3]);
            end
        end
    endtask

    task automatic startup(input string tag);
        step(0, 1, 0, INC, '0);
        check({tag, "_valid_e1"}, bus.valid, 0);
        step(0, 1, 0, INC, '0);
        check({tag, "_valid_e2"}, bus.valid, 0);
        step(0, 1, 0, INC, '0);
        check({tag, "_valid_e3"}, bus.valid, 1);
        check({tag, "_first_sin"}, bus.sin_out, 402);
        check({tag, "_first_cos"}, bus.cos_out, 32765);
        s_arr[0] = bus.sin_out;
        c_arr[0] = bus.cos_out;
        step(0, 1, 0, INC, '0);
        check({tag, "_second_sin"}, bus.sin_out, 1206);
        s_arr[1] = bus.sin_out;
        c_arr[1] = bus.cos_out;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.phase_inc = '0;
        bus.phase_off = '0;
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);

        // Full period at one table step per sample
        startup("start");
        for (int n = 2; n <= 256; n++) begin
            step(0, 1, 0, INC, '0);
            s_arr[n] = bus.sin_out;
            c_arr[n] = bus.cos_out;
        end
        for (int n = 0; n < 128; n++) check("mirror", s_arr[n], s_arr[127 - n]);
        for (int n = 0; n < 128; n++) check("negate", s_arr[n], -s_arr[n + 128]);
        for (int n = 0; n < 192; n++) check("quadrature", c_arr[n], s_arr[n + 64]);
        check("wrap_sin", s_arr[256], s_arr[0]);
        check("wrap_cos", c_arr[256], c_arr[0]);

        // Enable low mid-stream
        snap_s = bus.sin_out;
        snap_c = bus.cos_out;
        repeat (5) begin
            step(0, 0, 0, INC, '0);
            check("freeze_sin", bus.sin_out, snap_s);
            check("freeze_cos", bus.cos_out, snap_c);
            check("freeze_valid", bus.valid, 1);
        end
        step(0, 1, 0, INC, '0);
        check("resume_sin", bus.sin_out, 1206);
        step(0, 1, 0, INC, '0);

        // clr after 40 samples
        step(1, 0, 0, '0, '0);
        repeat (42) step(0, 1, 0, INC, '0);
        step(0, 1, 1, INC, '0);
        check("clr_valid_0", bus.valid, 0);
        step(0, 1, 0, INC, '0);
        check("clr_valid_1", bus.valid, 0);
        step(0, 1, 0, INC, '0);
        check("clr_valid_2", bus.valid, 0);
        step(0, 1, 0, INC, '0);
        check("clr_valid_3", bus.valid, 1);
        check("clr_restart_sin", bus.sin_out, 402);

        // Zero tuning word at half-period offset
        step(0, 0, 1, '0, HALF);
        repeat (4) step(0, 1, 0, '0, HALF);
        check("steady_sin", bus.sin_out, -402);
        check("steady_cos", bus.cos_out, -32765);
        check("steady_valid", bus.valid, 1);

        // Randomized tuning, offset, enable and clear
        inc_r = $urandom;
        off_r = $urandom;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) inc_r = $urandom;
            if ($urandom_range(0, 15) == 0) off_r = $urandom;
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, inc_r, off_r);
        end

        // Reset while streaming, with clr asserted at the same time
        repeat (10) step(0, 1, 0, INC, '0);
        step(1, 1, 1, INC, '0);
        check("rstclr_sin", bus.sin_out, 0);
        check("rstclr_valid", bus.valid, 0);
        startup("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
